r88_int_seq: RTL and testbench

//  Interrupt/reset entry sequencer for the Rocket88 core. Latches NMI edges and IRQ level,

---
 rtl/r88_int_seq.sv | 235 +++++++++++++++++++++++
 tb/tb_r88_int_seq.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/r88_int_seq.sv
// Rocket88 interrupt/reset entry sequencer: arbitrates reset > NMI > IRQ at instruction
// boundaries, pushes PC/flags, fetches the 16-bit vector and reloads PC/SP.
module r88_int_seq #(
  parameter logic [15:0] VEC_RST = 16'hFFFA,
  parameter logic [15:0] VEC_NMI = 16'hFFFC,
  parameter logic [15:0] VEC_IRQ = 16'hFFFE
) (
  input  logic        sysClock,
  input  logic        resetReq,
  input  logic        nmiReq,
  input  logic        irq,
  input  logic        irqEn,
  input  logic        instrBoundary,
  input  logic [15:0] pc,
  input  logic [15:0] sp,
  input  logic [7:0]  flags,
  input  logic        memReady,
  input  logic [7:0]  memData,
  output logic [15:0] addr,
  output logic [7:0]  dOut,
  output logic        readMem,
  output logic        writeMem,
  output logic        busy,
  output logic        pcLoad,
  output logic [15:0] pcNew,
  output logic        spLoad,
  output logic [15:0] spNew,
  output logic        irqEnClr,
  output logic [1:0]  intAck
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned SW = 2;

  localparam logic [2:0] S_RST_HOLD = 3'd0;
  localparam logic [2:0] S_IDLE     = 3'd1;
  localparam logic [2:0] S_PUSH_PCH = 3'd2;
  localparam logic [2:0] S_PUSH_PCL = 3'd3;
  localparam logic [2:0] S_PUSH_F   = 3'd4;
  localparam logic [2:0] S_VEC_L    = 3'd5;
  localparam logic [2:0] S_VEC_H    = 3'd6;
  localparam logic [2:0] S_LOAD     = 3'd7;

  localparam logic [SW-1:0] SRC_NMI = 2'b01;
  localparam logic [SW-1:0] SRC_IRQ = 2'b10;
  localparam logic [SW-1:0] SRC_RST = 2'b11;

  logic [2:0]    r_state;
  logic [SW-1:0] r_src;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_sp;
  logic [DW-1:0] r_flags;
  logic [DW-1:0] r_vec_lo;
  logic [DW-1:0] r_vec_hi;
  logic          r_nmi_prev;
  logic          r_nmi_pend;

  logic [2:0]    w_state_nxt;
  logic [SW-1:0] w_src_nxt;
  logic [AW-1:0] w_pc_nxt;
  logic [AW-1:0] w_sp_nxt;
  logic [DW-1:0] w_flags_nxt;
  logic [DW-1:0] w_vec_lo_nxt;
  logic [DW-1:0] w_vec_hi_nxt;
  logic [AW-1:0] w_vec_base;
  logic          w_nmi_edge;
  logic          w_nmi_any;
  logic          w_nmi_take;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_dout;
  logic          w_rd;
  logic          w_wr;
  logic          w_busy;
  logic          w_pcld;
  logic [AW-1:0] w_pcnew;
  logic          w_spld;
  logic [AW-1:0] w_spnew;
  logic          w_irqclr;
  logic [SW-1:0] w_ack;

  // A same-cycle edge counts at arbitration so a boundary NMI is not lost a cycle
  assign w_nmi_edge = nmiReq & ~r_nmi_prev;
  assign w_nmi_any  = r_nmi_pend | w_nmi_edge;

  // Next state, captured context, and outputs decoded from the next state
  always_comb begin
    w_state_nxt  = r_state;
    w_src_nxt    = r_src;
    w_pc_nxt     = r_pc;
    w_sp_nxt     = r_sp;
    w_flags_nxt  = r_flags;
    w_vec_lo_nxt = r_vec_lo;
    w_vec_hi_nxt = r_vec_hi;
    w_nmi_take   = 1'b0;
    w_vec_base   = VEC_RST;
    w_addr       = '0;
    w_dout       = '0;
    w_rd         = 1'b0;
    w_wr         = 1'b0;
    w_busy       = 1'b0;
    w_pcld       = 1'b0;
    w_pcnew      = '0;
    w_spld       = 1'b0;
    w_spnew      = '0;
    w_irqclr     = 1'b0;
    w_ack        = '0;

    case (r_state)
      S_RST_HOLD: begin
        w_state_nxt = S_VEC_L;
        w_src_nxt   = SRC_RST;
      end
      S_IDLE: begin
        if (instrBoundary && (w_nmi_any || (irq && irqEn))) begin
          w_state_nxt = S_PUSH_PCH;
          w_src_nxt   = w_nmi_any ? SRC_NMI : SRC_IRQ;
          w_nmi_take  = w_nmi_any;
          w_pc_nxt    = pc;
          w_sp_nxt    = sp;
          w_flags_nxt = flags;
        end
      end
      S_PUSH_PCH: if (memReady) w_state_nxt = S_PUSH_PCL;
      S_PUSH_PCL: if (memReady) w_state_nxt = S_PUSH_F;
      S_PUSH_F:   if (memReady) w_state_nxt = S_VEC_L;
      S_VEC_L: begin
        if (memReady) begin
          w_vec_lo_nxt = memData;
          w_state_nxt  = S_VEC_H;
        end
      end
      S_VEC_H: begin
        if (memReady) begin
          w_vec_hi_nxt = memData;
          w_state_nxt  = S_LOAD;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    case (w_src_nxt)
      SRC_NMI: w_vec_base = VEC_NMI;
      SRC_IRQ: w_vec_base = VEC_IRQ;
      default: w_vec_base = VEC_RST;
    endcase

    case (w_state_nxt)
      S_PUSH_PCH: begin
        w_wr   = 1'b1;
        w_addr = w_sp_nxt;
        w_dout = w_pc_nxt[15:8];
      end
      S_PUSH_PCL: begin
        w_wr   = 1'b1;
        w_addr = w_sp_nxt - AW'(1);
        w_dout = w_pc_nxt[7:0];
      end
      S_PUSH_F: begin
        w_wr   = 1'b1;
        w_addr = w_sp_nxt - AW'(2);
        w_dout = w_flags_nxt;
      end
      S_VEC_L: begin
        w_rd   = 1'b1;
        w_addr = w_vec_base;
      end
      S_VEC_H: begin
        w_rd   = 1'b1;
        w_addr = w_vec_base + AW'(1);
      end
      S_LOAD: begin
        w_pcld   = 1'b1;
        w_pcnew  = {w_vec_hi_nxt, w_vec_lo_nxt};
        w_ack    = w_src_nxt;
        w_irqclr = 1'b1;
        if (w_src_nxt != SRC_RST) begin
          w_spld  = 1'b1;
          w_spnew = w_sp_nxt - AW'(3);
        end
      end
      default: ;
    endcase

    w_busy = (w_state_nxt != S_IDLE) && (w_state_nxt != S_RST_HOLD);
  end

  // State, context and registered outputs; reset aborts any bus cycle at the next edge
  always_ff @(posedge sysClock) begin
    if (resetReq) begin
      r_state    <= S_RST_HOLD;
      r_src      <= '0;
      r_pc       <= '0;
      r_sp       <= '0;
      r_flags    <= '0;
      r_vec_lo   <= '0;
      r_vec_hi   <= '0;
      r_nmi_prev <= 1'b0;
      r_nmi_pend <= 1'b0;
      addr       <= '0;
      dOut       <= '0;
      readMem    <= 1'b0;
      writeMem   <= 1'b0;
      busy       <= 1'b0;
      pcLoad     <= 1'b0;
      pcNew      <= '0;
      spLoad     <= 1'b0;
      spNew      <= '0;
      irqEnClr   <= 1'b0;
      intAck     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_src      <= w_src_nxt;
      r_pc       <= w_pc_nxt;
      r_sp       <= w_sp_nxt;
      r_flags    <= w_flags_nxt;
      r_vec_lo   <= w_vec_lo_nxt;
      r_vec_hi   <= w_vec_hi_nxt;
      r_nmi_prev <= nmiReq;
      r_nmi_pend <= w_nmi_take ? 1'b0 : (r_nmi_pend | w_nmi_edge);
      addr       <= w_addr;
      dOut       <= w_dout;
      readMem    <= w_rd;
      writeMem   <= w_wr;
      busy       <= w_busy;
      pcLoad     <= w_pcld;
      pcNew      <= w_pcnew;
      spLoad     <= w_spld;
      spNew      <= w_spnew;
      irqEnClr   <= w_irqclr;
      intAck     <= w_ack;
    end
  end

endmodule

// File: tb/tb_r88_int_seq.sv
// Self-checking bench for r88_int_seq: bus monitor queues compared against a
// transaction-level model of interrupt entry (pushes, vector reads, LOAD strobe).
module tb_r88_int_seq;

  logic        sysClock = 1'b0;
  logic        resetReq, nmiReq, irq, irqEn, instrBoundary, memReady;
  logic [15:0] pc, sp;
  logic [7:0]  flags, memData;
  logic [15:0] addr, pcNew, spNew;
  logic [7:0]  dOut;
  logic        readMem, writeMem, busy, pcLoad, spLoad, irqEnClr;
  logic [1:0]  intAck;
  logic [63:0] all_out;

  always #5 sysClock = ~sysClock;

  r88_int_seq dut (
    .sysClock(sysClock), .resetReq(resetReq), .nmiReq(nmiReq), .irq(irq), .irqEn(irqEn),
    .instrBoundary(instrBoundary), .pc(pc), .sp(sp), .flags(flags), .memReady(memReady),
    .memData(memData), .addr(addr), .dOut(dOut), .readMem(readMem), .writeMem(writeMem),
    .busy(busy), .pcLoad(pcLoad), .pcNew(pcNew), .spLoad(spLoad), .spNew(spNew),
    .irqEnClr(irqEnClr), .intAck(intAck)
  );

  assign all_out = {addr, dOut, readMem, writeMem, busy, pcLoad, pcNew, spLoad, spNew,
                    irqEnClr, intAck};

  // Vector ROM at FFFA..FFFF; garbage when no read handshake is in progress
  logic [7:0] vec_mem [0:5];
  always_comb begin
    memData = 8'hEE;
    if (readMem && memReady && addr >= 16'hFFFA) memData = vec_mem[3'(addr - 16'hFFFA)];
  end

  typedef struct packed {logic [15:0] a; logic [7:0] d;} wr_t;
  typedef struct packed {logic [15:0] pc_new; logic sp_ld; logic [15:0] sp_new;
                         logic clr; logic [1:0] ack;} ld_t;
  wr_t         wq[$];
  logic [15:0] rq[$];
  ld_t         lq[$];

  // Completed bus transfers and LOAD strobes, sampled mid-cycle
  always @(negedge sysClock) begin
    if (writeMem && memReady) wq.push_back(wr_t'{a: addr, d: dOut});
    if (readMem && memReady) rq.push_back(addr);
    if (pcLoad) lq.push_back(ld_t'{pc_new: pcNew, sp_ld: spLoad, sp_new: spNew,
                                   clr: irqEnClr, ack: intAck});
  end

  int   n_tests = 0;
  int   n_fail  = 0;
  bit   rdy_rand = 1'b0;
  logic m_nmi_pend = 1'b0;

  task automatic step();
    @(posedge sysClock);
    #1;
    if (rdy_rand) memReady = ($urandom_range(0, 3) != 0);
  endtask

  task automatic drive_nmi(input logic v);
    if (v && !nmiReq) m_nmi_pend = 1'b1;
    nmiReq = v;
  endtask

  task automatic clear_q();
    wq.delete(); rq.delete(); lq.delete();
  endtask

  task automatic run_to_idle(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      step();
      if (busy === 1'b0) ok = 1'b1;
    end
  endtask

  function automatic logic [15:0] vec_of(input logic [1:0] src);
    case (src)
      2'b01:   return 16'hFFFC;
      2'b10:   return 16'hFFFE;
      default: return 16'hFFFA;
    endcase
  endfunction

  function automatic logic [7:0] rom(input logic [15:0] a);
    return vec_mem[3'(a - 16'hFFFA)];
  endfunction

  function automatic ld_t model_load(input logic [1:0] src, input logic [15:0] spv);
    logic [15:0] v;
    v = vec_of(src);
    return ld_t'{pc_new: {rom(v + 16'd1), rom(v)}, sp_ld: (src != 2'b11),
                 sp_new: (src != 2'b11) ? spv - 16'd3 : 16'h0, clr: 1'b1, ack: src};
  endfunction

  task automatic test_reset();
    bit  ok;
    ld_t exp;
    rdy_rand = 0; memReady = 1; resetReq = 1; nmiReq = 0; irq = 0; irqEn = 0;
    instrBoundary = 0; pc = 0; sp = 0; flags = 0; m_nmi_pend = 0;
    vec_mem[0] = 8'h34; vec_mem[1] = 8'h12;
    for (int k = 2; k < 6; k++) vec_mem[k] = 8'($urandom);
    repeat (3) step();
    n_tests++;
    if (all_out !== 64'h0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", all_out); end
    resetReq = 0; clear_q(); step();
    n_tests++;
    if ({busy, readMem, writeMem, addr} !== {3'b110, 16'hFFFA}) begin
      n_fail++; $display("FAIL reset_first_read: got busy=%b rd=%b wr=%b addr=%h want 1 1 0 fffa",
                         busy, readMem, writeMem, addr);
    end
    run_to_idle(50, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL reset_timeout: got busy=%b want 0", busy); end
    n_tests++;
    if (rq.size() != 2 || rq[0] !== 16'hFFFA || rq[1] !== 16'hFFFB) begin
      n_fail++; $display("FAIL reset_reads: got n=%0d want FFFA,FFFB", rq.size());
    end
    exp = model_load(2'b11, 16'h0);
    n_tests++;
    if (lq.size() != 1 || lq[0] !== exp) begin
      n_fail++; $display("FAIL reset_load: got n=%0d %h want %h", lq.size(),
                         (lq.size() > 0) ? lq[0] : ld_t'(0), exp);
    end
    n_tests++;
    if (wq.size() != 0) begin n_fail++; $display("FAIL reset_no_push: got %0d writes want 0", wq.size()); end
  endtask

  task automatic test_irq_entry();
    bit  ok, bad;
    wr_t exp_w [3];
    ld_t exp;
    vec_mem[4] = 8'($urandom); vec_mem[5] = 8'($urandom);
    pc = 16'h4321; sp = 16'h01FF; flags = 8'hA5; irq = 1; irqEn = 1; instrBoundary = 1;
    clear_q(); step();
    instrBoundary = 0; irq = 0;
    pc = 16'($urandom); sp = 16'($urandom); flags = 8'($urandom);
    n_tests++;
    if ({writeMem, readMem, busy, addr, dOut} !== {3'b101, 16'h01FF, 8'h43}) begin
      n_fail++; $display("FAIL irq_latency: got wr=%b rd=%b busy=%b addr=%h d=%h want 1 0 1 01ff 43",
                         writeMem, readMem, busy, addr, dOut);
    end
    repeat (5) step();
    n_tests++;
    if ({pcLoad, spLoad, spNew, intAck, irqEnClr} !== {2'b11, 16'h01FC, 2'b10, 1'b1}) begin
      n_fail++; $display("FAIL irq_load_cycle: got pcld=%b spld=%b spNew=%h ack=%b clr=%b want 1 1 01fc 10 1",
                         pcLoad, spLoad, spNew, intAck, irqEnClr);
    end
    run_to_idle(5, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL irq_idle: got busy=%b want 0", busy); end
    exp_w[0] = wr_t'{a: 16'h01FF, d: 8'h43};
    exp_w[1] = wr_t'{a: 16'h01FE, d: 8'h21};
    exp_w[2] = wr_t'{a: 16'h01FD, d: 8'hA5};
    bad = (wq.size() != 3);
    for (int k = 0; k < 3; k++) if (!bad && wq[k] !== exp_w[k]) bad = 1'b1;
    n_tests++;
    if (bad) begin n_fail++; $display("FAIL irq_pushes: got n=%0d first=%h want 3 writes from %h",
                                      wq.size(), (wq.size() > 0) ? wq[0] : wr_t'(0), exp_w[0]); end
    n_tests++;
    if (rq.size() != 2 || rq[0] !== 16'hFFFE || rq[1] !== 16'hFFFF) begin
      n_fail++; $display("FAIL irq_reads: got n=%0d want FFFE,FFFF", rq.size());
    end
    exp = model_load(2'b10, 16'h01FF);
    n_tests++;
    if (lq.size() != 1 || lq[0] !== exp) begin
      n_fail++; $display("FAIL irq_load: got n=%0d %h want %h", lq.size(),
                         (lq.size() > 0) ? lq[0] : ld_t'(0), exp);
    end
  endtask

  task automatic test_nmi_vs_irq();
    bit          ok;
    logic [15:0] sp_v;
    ld_t         exp;
    vec_mem[2] = 8'($urandom); vec_mem[3] = 8'($urandom);
    sp_v = 16'($urandom); pc = 16'($urandom); sp = sp_v; flags = 8'($urandom);
    irq = 1; irqEn = 1; drive_nmi(1); instrBoundary = 1;
    m_nmi_pend = 0;
    clear_q(); step();
    instrBoundary = 0; drive_nmi(0);
    run_to_idle(50, ok);
    exp = model_load(2'b01, sp_v);
    n_tests++;
    if (!ok || rq.size() != 2 || rq[0] !== 16'hFFFC || rq[1] !== 16'hFFFD) begin
      n_fail++; $display("FAIL nmi_wins_reads: got ok=%b n=%0d first=%h want FFFC,FFFD", ok, rq.size(),
                         (rq.size() > 0) ? rq[0] : 16'h0);
    end
    n_tests++;
    if (lq.size() != 1 || lq[0] !== exp) begin
      n_fail++; $display("FAIL nmi_wins_load: got n=%0d %h want %h", lq.size(),
                         (lq.size() > 0) ? lq[0] : ld_t'(0), exp);
    end
    sp_v = 16'($urandom); sp = sp_v; instrBoundary = 1;
    clear_q(); step();
    instrBoundary = 0; irq = 0;
    n_tests++;
    if (writeMem !== 1'b1 || addr !== sp_v) begin
      n_fail++; $display("FAIL irq_after_nmi_start: got wr=%b addr=%h want 1 %h", writeMem, addr, sp_v);
    end
    run_to_idle(50, ok);
    exp = model_load(2'b10, sp_v);
    n_tests++;
    if (!ok || lq.size() != 1 || lq[0] !== exp) begin
      n_fail++; $display("FAIL irq_after_nmi_load: got ok=%b n=%0d %h want %h", ok, lq.size(),
                         (lq.size() > 0) ? lq[0] : ld_t'(0), exp);
    end
  endtask

  task automatic test_irq_masked();
    bit masked_ok;
    irq = 1; irqEn = 0; instrBoundary = 1; masked_ok = 1'b1;
    clear_q();
    repeat (3) begin step(); if (busy !== 1'b0 || writeMem !== 1'b0) masked_ok = 1'b0; end
    n_tests++;
    if (!masked_ok) begin n_fail++; $display("FAIL irq_masked: got busy=%b wr=%b want 0 0", busy, writeMem); end
    irq = 0; drive_nmi(1);
    for (int c = 0; c < 30; c++) begin
      step();
      if (c == 9) drive_nmi(0);
    end
    m_nmi_pend = 0;
    instrBoundary = 0;
    n_tests++;
    if (lq.size() != 1 || lq[0].ack !== 2'b01 || busy !== 1'b0) begin
      n_fail++; $display("FAIL nmi_single_entry: got loads=%0d ack=%b busy=%b want 1 01 0", lq.size(),
                         (lq.size() > 0) ? lq[0].ack : 2'b00, busy);
    end
  endtask

  task automatic test_stall();
    bit          ok;
    logic [15:0] pc_v;
    logic [7:0]  fl_v;
    pc_v = 16'($urandom); fl_v = 8'($urandom);
    pc = pc_v; sp = 16'h01FF; flags = fl_v; irq = 1; irqEn = 1; instrBoundary = 1; memReady = 1;
    clear_q(); step();
    instrBoundary = 0; irq = 0;
    step();
    memReady = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      n_tests++;
      if ({writeMem, busy, addr, dOut} !== {2'b11, 16'h01FE, pc_v[7:0]}) begin
        n_fail++; $display("FAIL stall_hold_%0d: got wr=%b busy=%b addr=%h d=%h want 1 1 01fe %h",
                           c, writeMem, busy, addr, dOut, pc_v[7:0]);
      end
    end
    memReady = 1;
    step();
    n_tests++;
    if ({writeMem, addr, dOut} !== {1'b1, 16'h01FD, fl_v}) begin
      n_fail++; $display("FAIL stall_release: got wr=%b addr=%h d=%h want 1 01fd %h", writeMem, addr, dOut, fl_v);
    end
    run_to_idle(50, ok);
    n_tests++;
    if (!ok || wq.size() != 3 || wq[1] !== wr_t'{a: 16'h01FE, d: pc_v[7:0]}) begin
      n_fail++; $display("FAIL stall_pushes: got ok=%b n=%0d want 3", ok, wq.size());
    end
  endtask

  task automatic test_reset_abort();
    bit  ok, found;
    ld_t exp;
    pc = 16'($urandom); sp = 16'($urandom); irq = 1; irqEn = 1; instrBoundary = 1; found = 1'b0;
    step();
    instrBoundary = 0; irq = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      step();
      if (readMem === 1'b1 && addr === 16'hFFFF) found = 1'b1;
    end
    n_tests++;
    if (!found) begin n_fail++; $display("FAIL abort_reach_vech: got addr=%h want ffff", addr); end
    resetReq = 1;
    step();
    n_tests++;
    if (all_out !== 64'h0) begin n_fail++; $display("FAIL abort_outputs: got %h want 0", all_out); end
    step();
    m_nmi_pend = 0; resetReq = 0;
    clear_q();
    run_to_idle(50, ok);
    exp = model_load(2'b11, 16'h0);
    n_tests++;
    if (!ok || lq.size() != 1 || lq[0] !== exp) begin
      n_fail++; $display("FAIL abort_rst_load: got ok=%b n=%0d %h want %h", ok, lq.size(),
                         (lq.size() > 0) ? lq[0] : ld_t'(0), exp);
    end
    n_tests++;
    if (wq.size() != 0 || rq.size() != 2 || rq[0] !== 16'hFFFA) begin
      n_fail++; $display("FAIL abort_rst_bus: got writes=%0d reads=%0d want 0 2", wq.size(), rq.size());
    end
  endtask

  task automatic test_wrap();
    bit          ok, bad;
    logic [15:0] pc_v;
    logic [7:0]  fl_v;
    wr_t         exp_w [3];
    pc_v = 16'($urandom); fl_v = 8'($urandom);
    pc = pc_v; sp = 16'h0001; flags = fl_v; irq = 1; irqEn = 1; instrBoundary = 1;
    clear_q(); step();
    instrBoundary = 0; irq = 0;
    run_to_idle(50, ok);
    exp_w[0] = wr_t'{a: 16'h0001, d: pc_v[15:8]};
    exp_w[1] = wr_t'{a: 16'h0000, d: pc_v[7:0]};
    exp_w[2] = wr_t'{a: 16'hFFFF, d: fl_v};
    bad = !ok || (wq.size() != 3);
    for (int k = 0; k < 3; k++) if (!bad && wq[k] !== exp_w[k]) bad = 1'b1;
    n_tests++;
    if (bad) begin n_fail++; $display("FAIL wrap_pushes: got n=%0d last=%h want %h", wq.size(),
                                      (wq.size() > 2) ? wq[2] : wr_t'(0), exp_w[2]); end
    n_tests++;
    if (lq.size() != 1 || lq[0].sp_new !== 16'hFFFE || lq[0].sp_ld !== 1'b1) begin
      n_fail++; $display("FAIL wrap_spnew: got n=%0d spNew=%h want fffe", lq.size(),
                         (lq.size() > 0) ? lq[0].sp_new : 16'h0);
    end
  endtask

  task automatic test_random();
    bit          done, bad;
    logic [1:0]  src;
    logic [15:0] pc_v, sp_v;
    logic [7:0]  fl_v;
    wr_t         exp_w [3];
    ld_t         exp;
    rdy_rand = 1;
    for (int it = 0; it < 12; it++) begin
      for (int k = 2; k < 6; k++) vec_mem[k] = 8'($urandom);
      pc_v = 16'($urandom); fl_v = 8'($urandom);
      sp_v = (it % 4 == 0) ? 16'($urandom_range(0, 2)) : 16'($urandom);
      pc = pc_v; sp = sp_v; flags = fl_v;
      irq = 1'($urandom); irqEn = 1'($urandom);
      drive_nmi($urandom_range(0, 2) == 0);
      src = m_nmi_pend ? 2'b01 : (irq && irqEn) ? 2'b10 : 2'b00;
      if (src == 2'b01) m_nmi_pend = 0;
      instrBoundary = 1;
      clear_q(); step();
      instrBoundary = 0; irq = 0;
      if (src == 2'b00) begin
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rand_%0d_no_entry: got busy=%b want 0", it, busy); end
        continue;
      end
      done = 1'b0;
      for (int c = 0; c < 300 && !done; c++) begin
        step();
        if (busy === 1'b0) done = 1'b1;
        else begin
          instrBoundary = 1'($urandom); irq = 1'($urandom); irqEn = 1'($urandom);
          drive_nmi($urandom_range(0, 3) == 0);
          pc = 16'($urandom); sp = 16'($urandom); flags = 8'($urandom);
        end
      end
      instrBoundary = 0; irq = 0;
      n_tests++;
      if (!done) begin n_fail++; $display("FAIL rand_%0d_timeout: got busy=%b want 0", it, busy); end
      exp_w[0] = wr_t'{a: sp_v, d: pc_v[15:8]};
      exp_w[1] = wr_t'{a: sp_v - 16'd1, d: pc_v[7:0]};
      exp_w[2] = wr_t'{a: sp_v - 16'd2, d: fl_v};
      bad = (wq.size() != 3);
      for (int k = 0; k < 3; k++) if (!bad && wq[k] !== exp_w[k]) bad = 1'b1;
      n_tests++;
      if (bad) begin n_fail++; $display("FAIL rand_%0d_pushes: got n=%0d first=%h want %h", it, wq.size(),
                                        (wq.size() > 0) ? wq[0] : wr_t'(0), exp_w[0]); end
      n_tests++;
      if (rq.size() != 2 || rq[0] !== vec_of(src) || rq[1] !== vec_of(src) + 16'd1) begin
        n_fail++; $display("FAIL rand_%0d_reads: got n=%0d first=%h want %h", it, rq.size(),
                           (rq.size() > 0) ? rq[0] : 16'h0, vec_of(src));
      end
      exp = model_load(src, sp_v);
      n_tests++;
      if (lq.size() != 1 || lq[0] !== exp) begin
        n_fail++; $display("FAIL rand_%0d_load: got n=%0d %h want %h", it, lq.size(),
                           (lq.size() > 0) ? lq[0] : ld_t'(0), exp);
      end
    end
    rdy_rand = 0; memReady = 1;
  endtask

  initial begin
    test_reset();
    test_irq_entry();
    test_nmi_vs_irq();
    test_irq_masked();
    test_stall();
    test_reset_abort();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
